// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serializer that is
// paced by the shared oversample strobe.
module uart_tx #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [7:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [7:0]       shift_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [2:0]       bit_idx_q;
  logic             tx_q;

  logic push, pop, bit_end, fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign din_ready     = (count_q < CntW'(DEPTH));
  assign push          = din_valid && din_ready;
  assign bit_end       = tick && (tick_cnt_q == TickW'(OVERSAMPLE - 1));

  // Pops happen from IDLE or at the end of a stop bit, giving back-to-back frames.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = fifo_nonempty;
      StStop:  pop = bit_end && fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // tx is registered from the current state, so it trails state changes by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (state_q != StIdle && tick) begin
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + TickW'(1);
      end
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (bit_end) state_q <= StData;
        end
        StData: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (pop) begin
              shift_q   <= mem_q[rd_ptr_q];
              bit_idx_q <= '0;
              state_q   <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || fifo_nonempty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset/idle, single frames at two tick rates, a burst with
// producer back-pressure and same-edge push/pop, and reset in the middle of a frame.
module tb_uart_tx;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned OVERSAMPLE = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, tx, busy;
  logic [2:0] fifo_count;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cycle = 0, tick_ph = 0, tick_div = 1, bit_clks = 16;

  // Frames decoded by the line monitor.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_ok[$];

  uart_tx #(.DEPTH(DEPTH), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // Mid-bit sampler: waits for a start bit, then samples each bit at its centre.
  initial begin : monitor
    int         t0;
    logic [7:0] b;
    logic       ok;
    forever begin
      @(posedge clk);
      #2;
      if (tx === 1'b0) begin
        t0 = cycle;
        repeat (bit_clks / 2) @(posedge clk);
        #2 ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(posedge clk);
          #2 b[i] = tx;
        end
        repeat (bit_clks) @(posedge clk);
        #2 ok = ok && (tx === 1'b1);
        rx_q.push_back(b);
        rx_t.push_back(t0);
        rx_ok.push_back(ok);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    tick_ph++;
    tick = (tick_div <= 1) || (tick_ph % tick_div == 0);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tx === lvl && n < 1000) begin
      cyc();
      n++;
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    rx_ok.delete();
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      cyc();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin : main
    int         n, n0, m, bad;
    logic       acc;
    logic [9:0] fr;
    logic [7:0] burst [5];
    logic [7:0] exp_b [7];

    // Reset and idle
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_count", fifo_count, 3'd0);
    bad = 0;
    repeat (200) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Single 0x55, tick tied high: 16 cycles per level
    clear_rx();
    din = 8'h55;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("s55_busy_push", busy, 1'b1);
    chk("s55_count_push", fifo_count, 3'd1);
    chk("s55_tx_push", tx, 1'b1);
    cyc();
    chk("s55_count_pop", fifo_count, 3'd0);
    chk("s55_tx_pop", tx, 1'b1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 16; k++) begin
        cyc();
        chk($sformatf("s55_tx_b%0d_k%0d", b, k), tx, fr[b]);
        if (b == 9 && k == 14) chk("s55_busy_last", busy, 1'b1);
      end
    end
    chk("s55_busy_end", busy, 1'b0);
    chk("s55_rx_n", rx_q.size(), 1);
    chk("s55_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h55);

    // 0xA3 with one tick every 4 clocks: 64 clocks per bit
    clear_rx();
    tick_div = 4;
    bit_clks = 64;
    din = 8'hA3;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    din = 8'h00;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      cyc();
      n++;
    end
    chk("a3_start_seen", n < 200, 1'b1);
    run_len(1'b0, n);
    chk("a3_start_len", (n >= 61) && (n <= 64), 1'b1);
    run_len(1'b1, n);
    chk("a3_run_b0_b1", n, 128);
    run_len(1'b0, n);
    chk("a3_run_b2_b4", n, 192);
    run_len(1'b1, n);
    chk("a3_run_b5", n, 64);
    run_len(1'b0, n);
    chk("a3_run_b6", n, 64);
    wait_idle("a3_idle", 400);
    chk("a3_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA3);
    chk("a3_rx_frame", (rx_ok.size() > 0) ? rx_ok[0] : 1'b0, 1'b1);

    // Burst of 5, then a held 6th byte, then a push on a STOP->START pop edge
    clear_rx();
    tick_div = 1;
    tick = 1'b1;
    bit_clks = 16;
    burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h3C;
    n0 = 0;
    for (int i = 0; i < 5; i++) begin
      din = burst[i];
      din_valid = 1'b1;
      acc = 1'b0;
      m = 0;
      while (!acc && m < 400) begin
        acc = din_ready;
        cyc();
        m++;
      end
      if (i == 0) n0 = cycle;
    end
    din_valid = 1'b0;
    chk("burst_count_full", fifo_count, 3'd4);
    chk("burst_ready_low", din_ready, 1'b0);

    din = 8'hC5;
    din_valid = 1'b1;
    acc = 1'b0;
    m = 0;
    while (!acc && m < 400) begin
      acc = din_ready;
      cyc();
      m++;
    end
    din_valid = 1'b0;
    chk("held_accept_edge", cycle - n0, 162);
    chk("held_count", fifo_count, 3'd4);

    while (cycle < n0 + 640) cyc();
    chk("pp_count_before", fifo_count, 3'd2);
    din = 8'h96;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("pp_count_after", fifo_count, 3'd2);

    wait_idle("burst_idle", 2000);
    exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'hFF; exp_b[3] = 8'h00;
    exp_b[4] = 8'h3C; exp_b[5] = 8'hC5; exp_b[6] = 8'h96;
    chk("burst_rx_n", rx_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("burst_rx_byte%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b[i]);
      chk($sformatf("burst_rx_frame%0d", i), (rx_ok.size() > i) ? rx_ok[i] : 1'b0, 1'b1);
      if (i > 0) begin
        chk($sformatf("burst_gap%0d", i),
            (rx_t.size() > i) ? rx_t[i] - rx_t[i-1] : -1, 160);
      end
    end

    // Reset during data bit 3 of 0x0F with two bytes queued
    clear_rx();
    din = 8'h0F;
    din_valid = 1'b1;
    cyc();
    m = cycle;
    din = 8'hAA;
    cyc();
    din = 8'hBB;
    cyc();
    din_valid = 1'b0;
    chk("mr_count_queued", fifo_count, 3'd2);
    while (cycle < m + 70) cyc();
    chk("mr_busy_before", busy, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr_tx", tx, 1'b1);
    chk("mr_count", fifo_count, 3'd0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_ready", din_ready, 1'b1);
    bad = 0;
    repeat (200) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mr_quiet", bad, 0);

    clear_rx();
    din = 8'h5A;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    wait_idle("mr_new_idle", 400);
    chk("mr_new_rx_n", rx_q.size(), 1);
    chk("mr_new_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h5A);
    chk("mr_new_frame", (rx_ok.size() > 0) ? rx_ok[0] : 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
